// File: rtl/tta_pkg.sv
// Shared definitions for the transport-triggered core: instruction field
// positions, FSM encoding and default geometry.
package tta_pkg;

  localparam int DEF_DW    = 24;
  localparam int DEF_NREG  = 32;
  localparam int DEF_NUNIT = 16;
  localparam int DEF_IAW   = 24;

  localparam int IW       = 24;
  localparam int OP_BIT   = 23;
  localparam int COND_BIT = 22;
  localparam int HL_BIT   = 21;
  localparam int DST_HI   = 18;
  localparam int DST_LO   = 12;
  localparam int SRC_HI   = 11;
  localparam int SRC_LO   = 5;
  localparam int LIT_HI   = 11;
  localparam int LIT_LO   = 0;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_DECODE  = 2'b01,
    ST_EXECUTE = 2'b10
  } state_e;

  // Unit index width; never zero so a single-unit build still has a port.
  function automatic int uw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tta_core_p_if.sv
// Instruction fetch and unit-port bus of the core; master is the core side.
interface tta_core_p_if
  import tta_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int NUNIT = DEF_NUNIT,
  parameter int IAW   = DEF_IAW
);
  localparam int UW = uw_of(NUNIT);

  logic [IAW-1:0] iaddr;
  logic           ivalid;
  logic [IW-1:0]  idata;
  logic           u_wr_en;
  logic [UW-1:0]  u_wr_addr;
  logic [DW-1:0]  u_wr_data;
  logic [UW-1:0]  u_rd_addr;
  logic [DW-1:0]  u_rd_data;
  logic           cmp_true;
  logic           bad_port;

  modport master (
    output iaddr, u_wr_en, u_wr_addr, u_wr_data, u_rd_addr, bad_port,
    input  ivalid, idata, u_rd_data, cmp_true
  );

  modport slave (
    input  iaddr, u_wr_en, u_wr_addr, u_wr_data, u_rd_addr, bad_port,
    output ivalid, idata, u_rd_data, cmp_true
  );
endinterface

// File: rtl/tta_regfile.sv
// Bus-attached register file: R0 hardwired to zero, top register is the PC.
module tta_regfile #(
  parameter int DW   = 24,
  parameter int NREG = 32,
  parameter int PW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  output logic [DW-1:0] pc_o
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i == '0) ? '0 : mem_q[raddr_i];
  assign pc_o    = mem_q[NREG-1];

endmodule

// File: rtl/tta_core_p.sv
// Three-cycle fetch/decode/execute move machine; one move per instruction,
// between registers, unit ports, or from an immediate literal.
module tta_core_p
  import tta_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int NREG  = DEF_NREG,
  parameter int NUNIT = DEF_NUNIT,
  parameter int IAW   = DEF_IAW
) (
  input  logic         clk,
  input  logic         rst,
  tta_core_p_if.master bus
);

  localparam int PW = $clog2(NREG);
  localparam int UW = uw_of(NUNIT);
  localparam logic [6:0] P_NREG = 7'(NREG);
  localparam logic [6:0] P_UEND = 7'(NREG + NUNIT);

  state_e         state_q;
  logic [IW-1:0]  ir_q;
  logic [IAW-1:0] iaddr_q;

  logic        op, cnd, hl, is_exe, is_fetch, commit;
  logic [6:0]  dst, src;
  logic [11:0] lit;
  logic        dst_reg, dst_unit, dst_bad, src_reg, src_unit, src_bad;

  logic          rf_we;
  logic [PW-1:0] rf_waddr, rf_raddr;
  logic [DW-1:0] rf_wdata, rf_rdata, rf_pc, base, mv_data;

  assign op  = ir_q[OP_BIT];
  assign cnd = ir_q[COND_BIT];
  assign hl  = ir_q[HL_BIT];
  assign dst = ir_q[DST_HI:DST_LO];
  assign src = ir_q[SRC_HI:SRC_LO];
  assign lit = ir_q[LIT_HI:LIT_LO];

  assign is_exe   = (state_q == ST_EXECUTE);
  assign is_fetch = (state_q == ST_FETCH);
  assign commit   = !cnd || bus.cmp_true;

  assign dst_reg  = (dst < P_NREG);
  assign dst_unit = !dst_reg && (dst < P_UEND);
  assign dst_bad  = !dst_reg && !dst_unit;
  assign src_reg  = (src < P_NREG);
  assign src_unit = !src_reg && (src < P_UEND);
  assign src_bad  = !src_reg && !src_unit;

  // The single read port serves the source of a move, or the destination
  // of an immediate when its low bits must be preserved.
  assign rf_raddr = op ? PW'(dst) : PW'(src);
  assign base     = dst_reg ? rf_rdata : '0;

  always_comb begin
    mv_data = '0;
    if (op) begin
      if (hl) mv_data = {lit, base[DW-13:0]};
      else    mv_data = DW'(lit);
    end else if (src_reg) begin
      mv_data = rf_rdata;
    end else if (src_unit) begin
      mv_data = bus.u_rd_data;
    end
  end

  // FETCH and EXECUTE never overlap, so the PC increment shares the write port.
  assign rf_we    = is_fetch || (is_exe && commit && dst_reg);
  assign rf_waddr = is_fetch ? PW'(NREG - 1) : PW'(dst);
  assign rf_wdata = is_fetch ? rf_pc + DW'(1) : mv_data;

  tta_regfile #(.DW(DW), .NREG(NREG), .PW(PW)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (rf_we),
    .waddr_i (rf_waddr),
    .wdata_i (rf_wdata),
    .raddr_i (rf_raddr),
    .rdata_o (rf_rdata),
    .pc_o    (rf_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      iaddr_q <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          iaddr_q <= IAW'(rf_pc);
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          if (bus.ivalid) begin
            ir_q    <= bus.idata;
            state_q <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: state_q <= ST_FETCH;
        default:    state_q <= ST_FETCH;
      endcase
    end
  end

  assign bus.iaddr     = iaddr_q;
  assign bus.u_wr_en   = is_exe && commit && dst_unit;
  assign bus.u_wr_addr = is_exe ? UW'(dst - P_NREG) : '0;
  assign bus.u_wr_data = is_exe ? mv_data : '0;
  assign bus.u_rd_addr = (is_exe && !op && src_unit) ? UW'(src - P_NREG) : '0;
  assign bus.bad_port  = is_exe && (dst_bad || (!op && src_bad));

endmodule

// File: doc/tta_core_p.md
TTA_CORE_P -- requirements
Module: tta_core_p

Interface
REQ-001 Parameter DW, default 24: move-bus and register data width; legal range 13..32.
REQ-002 Parameter NREG, default 32: bus-attached storage registers on ports 0..NREG-1; power of two, 4..64.
REQ-003 Parameter NUNIT, default 16: unit ports NREG..NREG+NUNIT-1; NREG+NUNIT <= 128.
REQ-004 Parameter IAW, default 24: instruction address width.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 iaddr  out  IAW  instruction fetch address.
REQ-008 ivalid  in  1  idata valid this cycle.
REQ-009 idata  in  24  instruction word.
REQ-010 u_wr_en  out  1  one-cycle unit write strobe.
REQ-011 u_wr_addr  out  ceil(log2(NUNIT))  unit index, i.e. destination port minus NREG.
REQ-012 u_wr_data  out  DW  unit write data.
REQ-013 u_rd_addr  out  ceil(log2(NUNIT))  unit index for a unit-port source.
REQ-014 u_rd_data  in  DW  combinational read data for u_rd_addr.
REQ-015 cmp_true  in  1  condition flag sampled in EXECUTE.
REQ-016 bad_port  out  1  one-cycle pulse on an out-of-range port.

Function
REQ-017 Instruction fields:
- [23] opcode: 0 = register move, 1 = immediate.
- [22] conditional.
- [21] high/low select.
- [18:12] destination port.
- [11:5] source port.
- [11:0] literal.
REQ-018 FSM states: FETCH -> DECODE -> EXECUTE -> FETCH; encoding 00/01/10; the unused code returns to FETCH the next cycle.
REQ-019 FETCH: iaddr <= R[NREG-1][IAW-1:0] (PC); PC <= PC+1, modulo 2^DW.
REQ-020 DECODE: hold while ivalid=0; on ivalid=1, latch idata into the instruction register and go to EXECUTE.
REQ-021 EXECUTE: the move commits iff conditional=0, or conditional=1 and cmp_true=1; otherwise no write of any kind occurs.
REQ-022 Register move: data = R[src] if src<NREG; u_rd_data if src is a unit port (u_rd_addr = src-NREG); else 0 with bad_port pulsed.
REQ-023 Immediate, hl=0: data = literal zero-extended to DW.
REQ-024 Immediate, hl=1: data = destination's current value with bits [DW-1:DW-12] replaced by the literal; for a unit destination the base value is 0.
REQ-025 Destination < NREG: R[dst] <= data at the EXECUTE edge.
REQ-026 Destination is a unit port: u_wr_en=1 for exactly that EXECUTE cycle, with u_wr_addr=dst-NREG and u_wr_data=data.
REQ-027 Destination >= NREG+NUNIT: write dropped; bad_port=1 for that cycle; bad_port is not gated by the condition.
REQ-028 R0 always reads 0; writes to R0 are discarded.
REQ-029 PC write: a committed write to R[NREG-1] in EXECUTE is the next fetch address; the FETCH increment never coincides with it.
REQ-030 Throughput is 3 cycles per instruction when ivalid=1 in the first DECODE cycle; each ivalid-low cycle adds one.
REQ-031 u_wr_en and bad_port are 0 in every state except EXECUTE.

Reset
REQ-032 rst=0 asynchronously forces: state=FETCH, all registers including PC = 0, instruction register = 0, iaddr=0, u_wr_en=0, u_wr_addr=0, u_wr_data=0, u_rd_addr=0, bad_port=0.
REQ-033 Reset asserted mid-instruction aborts it: no pending write completes.
REQ-034 After release, the first FETCH occurs on the first rising edge with rst=1 and drives iaddr=0.

Structure
REQ-035 Shared package tta_pkg holds the opcode, high/low and conditional bit positions, field slices, the FSM state encoding and the default DW/NREG/NUNIT.
REQ-036 Sub-module tta_regfile holds the register file: NREG x DW, one combinational read port, one write port, R0 hardwired to 0, PC exposed as a dedicated output.

Verification
REQ-037 Immediate lo: 0x80_1_005 (dst 1, lit 0x005) -> R1=0x000005 at cycle 3.
REQ-038 Immediate hi: then 0xA0_1_ABC -> R1=0xABC005.
REQ-039 Register move: 0x00_2_020 (R1->R2) -> R2=0xABC005; u_wr_en stays 0.
REQ-040 Conditional/unit: conditional move R2->port 32 with cmp_true=0 -> no strobe; with cmp_true=1 -> u_wr_en=1, u_wr_addr=0, u_wr_data=0xABC005.
REQ-041 Jump/stall: immediate lit 0x040 to port 31 -> next iaddr=0x40; ivalid held low 5 cycles -> FSM stays in DECODE, no writes.
REQ-042 Bad port/reset: destination 127 -> bad_port pulses, no write; rst=0 in EXECUTE -> all registers 0 and iaddr=0 after release.
